muestreo_adc_spi: RTL
=====================

// Module: muestreo_adc_spi
// PURPOSE
//  Upstream acquisition stage of the PID loop. Drives a 12-bit serial ADC
//  (16-sclk frame: 4 leading zeros, then data MSB first) at a fixed sample rate.
//  Converts each offset-binary code to signed two's-complement yk and pulses
//  datolisto, which starts the ek/pk/ik/dk computation downstream.
// PARAMETERS
//  N              16    width of yk; equals `N from constantes.h
//  ADC_BITS       12    ADC data bits per frame
//  FRAC_SHIFT      4    left shift applied to the centred code; N >= ADC_BITS+FRAC_SHIFT
//  CLK_DIV         4    clk cycles per sclk half-period (>=1)
//  SAMPLE_PERIOD 5000   clk cycles between conversion ticks; must be > 34*CLK_DIV+1
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  reset      in   1   asynchronous, active-low reset
//  enable     in   1   1 = sample timer runs; 0 = no new conversions
//  sdata      in   1   ADC serial data; changes after sclk falls
//  cs_n       out  1   ADC chip select, active low
//  sclk       out  1   ADC serial clock, idles high
//  yk         out  N   signed measurement, held between updates
//  datolisto  out  1   one-clk pulse: new yk valid this cycle
//  err_trama  out  1   one-clk pulse: frame rejected (nonzero leading bits)
//  overrun    out  1   sticky: tick arrived while a frame was in progress
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, cs_n=1, sclk=1, yk=0, datolisto=0,
//   err_trama=0, overrun=0, timer=0, shift reg=0. A frame in flight is aborted.
//  Timer: counts 0..SAMPLE_PERIOD-1 while enable=1, wraps to 0; tick=1 when
//   count==SAMPLE_PERIOD-1. enable=0 clears the count. First tick comes
//   SAMPLE_PERIOD cycles after enable rises.
//  FSM: IDLE -> SETUP -> SHIFT -> QUIET -> DONE -> IDLE.
//   IDLE : cs_n=1, sclk=1. On tick, go to SETUP. cs_n falls on that edge (edge 0).
//   SETUP: cs_n=0, sclk=1 for CLK_DIV cycles.
//   SHIFT: 16 sclk periods, each CLK_DIV cycles low then CLK_DIV cycles high.
//          sdata is shifted in MSB-first on every edge that drives sclk 0->1.
//          16 bits are captured in total.
//   QUIET: cs_n rises at edge 33*CLK_DIV. sclk=1. Hold CLK_DIV cycles.
//   DONE : single cycle, starting at edge 34*CLK_DIV, then back to IDLE.
//          If the top 16-ADC_BITS captured bits are all 0:
//            yk <= sext(code - 2^(ADC_BITS-1)) << FRAC_SHIFT, datolisto=1.
//          Otherwise: yk is unchanged, err_trama=1, datolisto stays 0.
//  Arithmetic: code is the low ADC_BITS captured bits, taken as unsigned. The
//   centring subtraction is done in ADC_BITS+1 bits, then sign-extended to N.
//   No saturation is needed (range fits by the parameter rule).
//  Latency: edge where cs_n falls -> datolisto high = 34*CLK_DIV clk cycles (136 at default).
//  Tick while not IDLE: tick is ignored, overrun<=1 (sticky until reset). The
//   current frame is unaffected.
//  enable falling mid-frame: the frame completes normally. No new tick follows.
//  datolisto and err_trama are never high in the same cycle. Each is exactly
//   1 clk wide per frame.
// TESTING
//  1 sdata frame 0000_1000_0000_0000 (code 0x800) -> yk=0x0000, datolisto pulse at edge 136.
//  2 code 0xFFF -> yk=0x7FF0. Code 0x000 -> yk=0x8000. Code 0x7FF -> yk=0xFFF0.
//  3 leading bits 0100 with code 0x123 -> err_trama 1-clk pulse, yk keeps its previous value,
//    no datolisto.
//  4 SAMPLE_PERIOD=100 override (< frame length) -> overrun=1 after 2nd tick; frames still
//    complete; sclk count per cs_n low = 16.
//  5 reset low at edge 60 of a frame -> cs_n=1, sclk=1, yk=0 immediately (async);
//    next frame starts SAMPLE_PERIOD cycles after reset release with enable=1.
//  6 enable 1->0 at edge 10 of a frame -> frame completes with datolisto; no further cs_n
//    activity for 3*SAMPLE_PERIOD cycles.

Source files
------------

// File: rtl/muestreo_adc_spi.sv
// muestreo_adc_spi: periodic 16-sclk serial ADC capture, offset-binary to signed yk with datolisto pulse
module muestreo_adc_spi #(
  parameter int N             = 16,
  parameter int ADC_BITS      = 12,
  parameter int FRAC_SHIFT    = 4,
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 5000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         sdata,
  output logic         cs_n,
  output logic         sclk,
  output logic [N-1:0] yk,
  output logic         datolisto,
  output logic         err_trama,
  output logic         overrun
);
  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int LB = 16 - ADC_BITS;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, QUIET, DONE} state_t;
  state_t state, state_d;
  logic [TW-1:0] cnt;
  logic [DW-1:0] div, div_d;
  logic [4:0] nbit, nbit_d;
  logic [15:0] sh, sh_d;
  logic [N-1:0] yk_d, ext;
  logic [ADC_BITS:0] cen;
  logic tick, div_end, ok, cs_n_d, sclk_d, dl_d, err_d;
  assign tick = enable && cnt == TW'(SAMPLE_PERIOD - 1);
  assign div_end = div == DW'(CLK_DIV - 1);
  assign ok = ~|sh[15 -: LB];
  assign cen = {1'b0, sh[ADC_BITS-1:0]} - {2'b01, {(ADC_BITS-1){1'b0}}};
  assign ext = {{(N-ADC_BITS-1){cen[ADC_BITS]}}, cen};
  // sample-rate timer; disabling clears it so the first tick lands a full period after enable
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (!enable || tick) ? '0 : cnt + 1'b1;
  // state and registered outputs; a tick outside IDLE only marks overrun
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      div <= '0;
      nbit <= '0;
      sh <= '0;
      cs_n <= 1'b1;
      sclk <= 1'b1;
      yk <= '0;
      datolisto <= 1'b0;
      err_trama <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_d;
      div <= div_d;
      nbit <= nbit_d;
      sh <= sh_d;
      cs_n <= cs_n_d;
      sclk <= sclk_d;
      yk <= yk_d;
      datolisto <= dl_d;
      err_trama <= err_d;
      overrun <= overrun | (tick && state != IDLE);
    end
  // frame sequencing: sdata is taken on the edge that raises sclk, 16 rises per frame
  always_comb begin
    state_d = state;
    div_d = div;
    nbit_d = nbit;
    sh_d = sh;
    cs_n_d = cs_n;
    sclk_d = sclk;
    yk_d = yk;
    dl_d = 1'b0;
    err_d = 1'b0;
    case (state)
      IDLE: if (tick) begin
        state_d = SETUP;
        cs_n_d = 1'b0;
        div_d = '0;
        nbit_d = '0;
      end
      SETUP: begin
        div_d = div_end ? '0 : div + 1'b1;
        if (div_end) begin
          state_d = SHIFT;
          sclk_d = 1'b0;
        end
      end
      SHIFT: begin
        div_d = div_end ? '0 : div + 1'b1;
        if (div_end && !sclk) begin
          sclk_d = 1'b1;
          sh_d = {sh[14:0], sdata};
          nbit_d = nbit + 1'b1;
        end else if (div_end && nbit == 5'd16) begin
          state_d = QUIET;
          cs_n_d = 1'b1;
        end else if (div_end) sclk_d = 1'b0;
      end
      QUIET: begin
        div_d = div_end ? '0 : div + 1'b1;
        if (div_end) begin
          state_d = DONE;
          dl_d = ok;
          err_d = !ok;
          yk_d = ok ? ext << FRAC_SHIFT : yk;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
